// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU test-vector controllers.
// Holds the sequencer state encoding, the default wait limit and the FP word width.
package fpu_ctrl_pkg;

  localparam int unsigned FpWidth        = 32;
  localparam int unsigned DefaultTimeout = 16;

  // 3-bit encoding leaves spare codes, so a corrupted state can be recovered.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3
  } seq_state_e;

endpackage

// File: rtl/wait_timer.sv
// Clearable, saturating wait counter with a terminal flag at Limit-1.
// Shared by FPU controllers that bound how long they wait on a handshake.
module wait_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCnt)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LastCnt);

endmodule

// File: rtl/fpu_vector_sequencer.sv
// Steps the FP adder through the vector ROM, one vector per button pulse,
// launching the FPU with a start/done handshake and flagging a silent FPU.
module fpu_vector_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_pulse,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [FpWidth-1:0] rom_a,
  input  logic [FpWidth-1:0] rom_b,
  output logic [FpWidth-1:0] fpu_a,
  output logic [FpWidth-1:0] fpu_b,
  output logic               fpu_start,
  input  logic               fpu_done,
  input  logic [FpWidth-1:0] fpu_result,
  output logic [FpWidth-1:0] result,
  output logic               result_valid,
  output logic               timeout_err,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_VEC - 1);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [FpWidth-1:0] fpu_a_q, fpu_a_d;
  logic [FpWidth-1:0] fpu_b_q, fpu_b_d;
  logic [FpWidth-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_err_q, timeout_err_d;

  logic               wait_term;
  logic [ADDR_W-1:0]  next_addr;

  wait_timer #(
    .Limit (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == StStart),
    .enable   (state_q == StWait),
    .terminal (wait_term)
  );

  assign next_addr = (rom_addr_q == LastAddr) ? '0 : rom_addr_q + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done takes priority over the timeout terminal cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (step_pulse) state_d = StLoad;
      StLoad:  state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (fpu_done || wait_term) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    fpu_start = (state_q == StStart);
    busy      = (state_q == StLoad) || (state_q == StStart) || (state_q == StWait);
  end

  // Datapath next-state
  always_comb begin
    rom_addr_d     = rom_addr_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;
    case (state_q)
      StIdle, StStart: ;
      StLoad: begin
        fpu_a_d        = rom_a;
        fpu_b_d        = rom_b;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
      end
      StWait: begin
        if (fpu_done) begin
          result_d       = fpu_result;
          result_valid_d = 1'b1;
          rom_addr_d     = next_addr;
        end else if (wait_term) begin
          timeout_err_d  = 1'b1;
          rom_addr_d     = next_addr;
        end
      end
      default: begin
        // Recovery from a corrupted state keeps the address and last result.
        fpu_a_d        = '0;
        fpu_b_d        = '0;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q     <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign fpu_a        = fpu_a_q;
  assign fpu_b        = fpu_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// Bench for fpu_vector_sequencer: table of step transactions with a behavioural
// FPU responder, plus hand-written reset-during-wait sequence.
module tb_fpu_vector_sequencer;

  localparam int ADDR_W  = 4;
  localparam int NUM_VEC = 3;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 99;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              step_pulse = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_a, rom_b;
  logic [31:0]       fpu_a, fpu_b;
  logic              fpu_start;
  logic              fpu_done = 1'b0;
  logic [31:0]       fpu_result = '0;
  logic [31:0]       result;
  logic              result_valid, timeout_err, busy;

  logic [31:0] rom_a_tbl [16];
  logic [31:0] rom_b_tbl [16];

  assign rom_a = rom_a_tbl[rom_addr];
  assign rom_b = rom_b_tbl[rom_addr];

  fpu_vector_sequencer #(
    .ADDR_W  (ADDR_W),
    .NUM_VEC (NUM_VEC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .step_pulse   (step_pulse),
    .rom_addr     (rom_addr),
    .rom_a        (rom_a),
    .rom_b        (rom_b),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_start    (fpu_start),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .result       (result),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int start_cnt = 0;
  always @(posedge clk) if (fpu_start) start_cnt <= start_cnt + 1;

  typedef struct {
    int          done_dly;   // WAIT cycle index of fpu_done; >= TIMEOUT means never
    logic [31:0] fpu_res;
    bit          noise;      // stray step pulses and fpu_done outside WAIT
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_result;
    bit          exp_valid;
    bit          exp_terr;
    logic [3:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    bit          valid;
    bit          terr;
    logic [3:0]  addr;
  } exp_t;

  vec_t vecs [7];
  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_step(input vec_t v);
    int   base;
    int   waited;
    exp_t e;
    base = start_cnt;
    exp_q.push_back('{v.exp_result, v.exp_valid, v.exp_terr, v.exp_addr});
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    check("busy_load", busy, 1);
    check("start_load", fpu_start, 0);
    if (v.noise) step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    check("start_hi", fpu_start, 1);
    check("fpu_a", fpu_a, v.exp_a);
    check("fpu_b", fpu_b, v.exp_b);
    check("valid_clr", result_valid, 0);
    check("terr_clr", timeout_err, 0);
    if (v.noise) begin
      fpu_done   = 1'b1;
      fpu_result = 32'hDEADBEEF;
    end
    tick();
    fpu_done = 1'b0;
    check("start_lo", fpu_start, 0);
    waited = 0;
    for (int i = 0; i < TIMEOUT && busy; i++) begin
      if (v.noise) step_pulse = (i == 0);
      if (i == v.done_dly) begin
        fpu_done   = 1'b1;
        fpu_result = v.fpu_res;
      end
      tick();
      fpu_done   = 1'b0;
      step_pulse = 1'b0;
      waited++;
    end
    check("wait_len", waited, (v.done_dly < TIMEOUT) ? v.done_dly + 1 : TIMEOUT);
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_fall: busy still 1 after %0d wait cycles, required 0", waited);
    end else if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: output seen with empty queue");
    end else begin
      e = exp_q.pop_front();
      check("result", result, e.result);
      check("result_valid", result_valid, e.valid);
      check("timeout_err", timeout_err, e.terr);
      check("rom_addr", rom_addr, e.addr);
    end
    check("launches", start_cnt - base, 1);
    if (v.noise) begin
      fpu_done   = 1'b1;
      fpu_result = 32'hCAFEF00D;
      tick();
      fpu_done = 1'b0;
      tick();
      check("idle_done_result", result, v.exp_result);
      check("idle_done_busy", busy, 0);
      check("idle_done_addr", rom_addr, v.exp_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_a_tbl[i] = '0;
      rom_b_tbl[i] = '0;
    end
    rom_a_tbl[0] = 32'h3F800000; rom_b_tbl[0] = 32'h40000000;
    rom_a_tbl[1] = 32'h40000000; rom_b_tbl[1] = 32'h40400000;
    rom_a_tbl[2] = 32'h41200000; rom_b_tbl[2] = 32'h3F800000;

    vecs[0] = '{1,     32'h40400000, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b0, 4'd1};
    vecs[1] = '{0,     32'h40A00000, 1'b0, 32'h40000000, 32'h40400000, 32'h40A00000, 1'b1, 1'b0, 4'd2};
    vecs[2] = '{3,     32'h41300000, 1'b0, 32'h41200000, 32'h3F800000, 32'h41300000, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{NEVER, 32'h00000000, 1'b0, 32'h3F800000, 32'h40000000, 32'h41300000, 1'b0, 1'b1, 4'd1};
    vecs[4] = '{15,    32'h40A00000, 1'b0, 32'h40000000, 32'h40400000, 32'h40A00000, 1'b1, 1'b0, 4'd2};
    vecs[5] = '{2,     32'h41300000, 1'b1, 32'h41200000, 32'h3F800000, 32'h41300000, 1'b1, 1'b0, 4'd0};
    vecs[6] = '{0,     32'h40400000, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b0, 4'd1};

    tick();
    tick();
    check("rst_addr", rom_addr, 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_start", fpu_start, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) begin
      do_step(vecs[k]);
      tick();
    end

    // Reset asserted mid-WAIT, then a late fpu_done that must be discarded.
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    tick();
    tick();
    tick();
    check("mid_wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_fpu_a", fpu_a, 0);
    check("arst_fpu_b", fpu_b, 0);
    check("arst_result", result, 0);
    check("arst_valid", result_valid, 0);
    check("arst_terr", timeout_err, 0);
    check("arst_start", fpu_start, 0);
    tick();
    reset      = 1'b0;
    fpu_done   = 1'b1;
    fpu_result = 32'h12345678;
    tick();
    fpu_done = 1'b0;
    tick();
    check("late_done_result", result, 0);
    check("late_done_valid", result_valid, 0);
    check("late_done_busy", busy, 0);
    check("late_done_addr", rom_addr, 0);

    do_step(vecs[0]);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
